// File: rtl/dm_lsu_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings,
// controller states and the byte-enable mask helper.
package dm_lsu_pkg;

   // Funct3[1:0] access-size encodings
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // Funct3 bit that selects zero-extension on loads
   localparam int unsigned F3_UNS_BIT = 2;

   // Controller states; explicit encodings keep the legacy values
   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Contiguous byte-enable mask of (1 << size) bytes starting at lane,
   // limited to the nb lanes that physically exist.
   function automatic logic [7:0] be_mask(input logic [1:0] size,
                                          input logic [2:0] lane,
                                          input int unsigned nb);
      logic [3:0]  nbytes;
      logic [15:0] m;
      nbytes = 4'd1 << size;
      m      = (16'h0001 << nbytes) - 16'h0001;
      m      = m << lane;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i >= nb) m[i] = 1'b0;
      end
      return m[7:0];
   endfunction

endpackage

// File: rtl/dm_lsu_mem_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface dm_lsu_mem_if #(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  MemRead;
   logic                  MemWrite;
   logic [DM_ADDRESS-1:0] a;
   logic [DATA_W-1:0]     wd;
   logic [2:0]            Funct3;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rd;
   logic                  fault;

   modport master (
      output req_valid, MemRead, MemWrite, a, wd, Funct3,
      input  req_ready, rsp_valid, rd, fault
   );

   modport slave (
      input  req_valid, MemRead, MemWrite, a, wd, Funct3,
      output req_ready, rsp_valid, rd, fault
   );
endinterface

// File: rtl/dm_lsu_mem_bram.sv
// Single-port byte-lane RAM: per-byte write enables, synchronous read,
// write has priority (read data on a write cycle is don't-care).
module dm_bram #(
   parameter int unsigned AW     = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [DATA_W/8-1:0] i_be,
   input  logic [AW-1:0]       i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic [DATA_W-1:0]   o_rdata
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Byte-masked write, otherwise registered read of the addressed word
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end else begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_lsu_mem.sv
// MEM-stage data memory: post-reset array clear, request decode and fault
// checks, store lane shifter, and a registered load aligner/extender.
module dm_lsu_mem
   import dm_lsu_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32
) (
   input logic          clk,
   input logic          reset,
   dm_lsu_mem_if.slave  bus
);
   localparam int unsigned NB = DATA_W / 8;
   localparam int unsigned LB = $clog2(NB);
   localparam int unsigned AW = DM_ADDRESS - LB;

   state_e              r_state;
   logic [AW-1:0]       r_cnt;

   // request-cycle values carried to the response cycle
   logic [LB-1:0]       r_lane;
   logic [1:0]          r_size;
   logic                r_uns;
   logic                r_load;
   logic                r_fault;

   // registered response
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rd;
   logic                r_rsp_fault;

   logic                w_ready;
   logic                w_acc;
   logic [1:0]          w_size;
   logic                w_uns;
   logic [LB-1:0]       w_lane;
   logic [2:0]          w_lane3;
   logic [AW-1:0]       w_widx;
   logic [2:0]          w_amask;
   logic                w_misal;
   logic                w_wide_bad;
   logic                w_fault;
   logic                w_st;
   logic [7:0]          w_be8;
   logic [DATA_W-1:0]   w_st_data;

   logic                w_ram_we;
   logic [NB-1:0]       w_ram_be;
   logic [AW-1:0]       w_ram_addr;
   logic [DATA_W-1:0]   w_ram_wdata;
   logic [DATA_W-1:0]   w_ram_rdata;

   logic [DATA_W-1:0]   w_sh;
   logic                w_sign;
   int unsigned         w_nbits;
   logic [DATA_W-1:0]   w_ext;

   assign w_ready = (r_state != CLEAR);
   assign w_acc   = bus.req_valid && w_ready;
   assign w_size  = bus.Funct3[1:0];
   assign w_uns   = bus.Funct3[F3_UNS_BIT];
   assign w_lane  = bus.a[LB-1:0];
   assign w_widx  = bus.a[DM_ADDRESS-1:LB];

   // Request decode: alignment, width legality and opcode sanity
   always_comb begin
      w_lane3         = '0;
      w_lane3[LB-1:0] = w_lane;
      case (w_size)
         SZ_B:    w_amask = 3'b000;
         SZ_H:    w_amask = 3'b001;
         SZ_W:    w_amask = 3'b011;
         default: w_amask = 3'b111;
      endcase
      w_misal    = |(bus.a[2:0] & w_amask);
      w_wide_bad = (DATA_W == 32) && ((w_size == SZ_D) || (bus.Funct3 == 3'b110));
      w_fault    = w_misal || w_wide_bad || (bus.Funct3 == 3'b111) ||
                   (bus.MemWrite && w_uns) || (bus.MemRead == bus.MemWrite);
      w_st       = w_acc && bus.MemWrite && !w_fault;
      w_be8      = be_mask(w_size, w_lane3, NB);
      w_st_data  = bus.wd << {w_lane, 3'b000};
   end

   // RAM port mux: the clear sweep owns the port until the array is zeroed
   always_comb begin
      if (r_state == CLEAR) begin
         w_ram_we    = 1'b1;
         w_ram_be    = '1;
         w_ram_addr  = r_cnt;
         w_ram_wdata = '0;
      end else begin
         w_ram_we    = w_st;
         w_ram_be    = w_be8[NB-1:0];
         w_ram_addr  = w_widx;
         w_ram_wdata = w_st_data;
      end
   end

   dm_bram #(
      .AW     (AW),
      .DATA_W (DATA_W)
   ) u_bram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_be    (w_ram_be),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   // Controller: sweep every word once after reset, then track pending response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == '1) r_state <= IDLE;
            end
            default: r_state <= w_acc ? RUN : IDLE;
         endcase
      end
   end

   // Capture lane/size/kind of the accepted request for the response cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lane  <= '0;
         r_size  <= SZ_B;
         r_uns   <= 1'b0;
         r_load  <= 1'b0;
         r_fault <= 1'b0;
      end else if (w_acc) begin
         r_lane  <= w_lane;
         r_size  <= w_size;
         r_uns   <= w_uns;
         r_load  <= bus.MemRead && !bus.MemWrite;
         r_fault <= w_fault;
      end
   end

   // Load aligner: shift the lane down, then sign- or zero-fill above size
   always_comb begin
      w_sh    = w_ram_rdata >> {r_lane, 3'b000};
      w_nbits = 32'd8 << r_size;
      if (w_nbits > DATA_W) w_nbits = DATA_W;
      case (r_size)
         SZ_B:    w_sign = !r_uns && w_sh[7];
         SZ_H:    w_sign = !r_uns && w_sh[15];
         SZ_W:    w_sign = !r_uns && w_sh[31];
         default: w_sign = !r_uns && w_sh[DATA_W-1];
      endcase
      w_ext = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         w_ext[i] = (i < w_nbits) ? w_sh[i] : w_sign;
      end
   end

   // Registered response: one pulse per accepted request, rd zero unless a good load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rd        <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         r_rsp_valid <= (r_state == RUN);
         r_rsp_fault <= (r_state == RUN) && r_fault;
         r_rd        <= ((r_state == RUN) && r_load && !r_fault) ? w_ext : '0;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rd        = r_rd;
   assign bus.fault     = r_rsp_fault;

endmodule

// File: tb/tb_dm_lsu_mem.sv
// Scoreboard bench for dm_lsu_mem: a 32-bit and a 64-bit instance are driven
// with directed and random requests; a byte-array model predicts responses.
module tb_dm_lsu_mem;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   dm_lsu_mem_if #(.DM_ADDRESS(9),  .DATA_W(32)) if32 ();
   dm_lsu_mem_if #(.DM_ADDRESS(10), .DATA_W(64)) if64 ();

   dm_lsu_mem #(.DM_ADDRESS(9), .DATA_W(32)) dut32 (
      .clk   (clk),
      .reset (reset),
      .bus   (if32.slave)
   );

   dm_lsu_mem #(.DM_ADDRESS(10), .DATA_W(64)) dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (if64.slave)
   );

   typedef struct {
      logic [63:0] rd;
      logic        flt;
      int          cyc;
   } exp_t;

   exp_t        q32[$];
   exp_t        q64[$];
   logic [7:0]  m32 [512];
   logic [7:0]  m64 [1024];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: memory is a flat byte array, accesses are little-endian byte runs
   function automatic void model(input bit d64, input bit rdv, input bit wrv,
                                 input int unsigned addr, input logic [63:0] wd,
                                 input logic [2:0] f3,
                                 output logic flt, output logic [63:0] rd);
      int unsigned n;
      logic [7:0]  b;
      n   = 1 << f3[1:0];
      flt = (rdv == wrv) || (f3 == 3'b111) || (wrv && f3[2]) || ((addr % n) != 0) ||
            (!d64 && (n == 8 || f3 == 3'b110));
      rd  = '0;
      if (flt) return;
      for (int unsigned i = 0; i < n; i++) begin
         if (wrv) begin
            b = 8'(wd >> (8 * i));
            if (d64) m64[10'(addr + i)] = b;
            else     m32[9'(addr + i)]  = b;
         end else begin
            b  = d64 ? m64[10'(addr + i)] : m32[9'(addr + i)];
            rd = rd | (64'(b) << (8 * i));
         end
      end
      if (rdv && !f3[2] && (((rd >> (8 * n - 1)) & 64'd1) != 0))
         rd = rd | (~64'd0 << (8 * n));
      if (!d64) rd = rd & 64'h0000_0000_FFFF_FFFF;
   endfunction

   task automatic cmp(input string nm, input exp_t e, input logic [63:0] rd, input logic flt);
      n_chk++;
      if (rd !== e.rd || flt !== e.flt || cyc != e.cyc) begin
         n_fail++;
         $display("FAIL %s: got rd=%h fault=%b cyc=%0d, want rd=%h fault=%b cyc=%0d",
                  nm, rd, flt, cyc, e.rd, e.flt, e.cyc);
      end
   endtask

   // Monitor: pop and compare on every response, flag strays and overdue entries
   always @(negedge clk) begin : mon
      exp_t e;
      if (if32.rsp_valid === 1'b1) begin
         if (q32.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp32_unexpected: got rsp_valid=1 at cyc=%0d, want no response", cyc);
         end else begin
            e = q32.pop_front();
            cmp("rsp32", e, {32'h0, if32.rd}, if32.fault);
         end
      end else if (q32.size() != 0 && q32[0].cyc < cyc) begin
         e = q32.pop_front();
         n_chk++; n_fail++;
         $display("FAIL rsp32_missing: got no response by cyc=%0d, want one at cyc=%0d", cyc, e.cyc);
      end
      if (if64.rsp_valid === 1'b1) begin
         if (q64.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp64_unexpected: got rsp_valid=1 at cyc=%0d, want no response", cyc);
         end else begin
            e = q64.pop_front();
            cmp("rsp64", e, if64.rd, if64.fault);
         end
      end else if (q64.size() != 0 && q64[0].cyc < cyc) begin
         e = q64.pop_front();
         n_chk++; n_fail++;
         $display("FAIL rsp64_missing: got no response by cyc=%0d, want one at cyc=%0d", cyc, e.cyc);
      end
   end

   // Drive one request for one cycle starting at posedge+1; push expectation on acceptance
   task automatic issue(input bit d64, input bit v, input bit rdv, input bit wrv,
                        input int unsigned addr, input logic [63:0] wd, input logic [2:0] f3,
                        input bit lit, input logic [63:0] lrd, input bit lflt);
      exp_t        e;
      logic        flt;
      logic [63:0] rd;
      logic        rdy;
      if (d64) begin
         if64.req_valid = v;  if64.MemRead = rdv; if64.MemWrite = wrv;
         if64.a = 10'(addr);  if64.wd = wd;       if64.Funct3 = f3;
      end else begin
         if32.req_valid = v;  if32.MemRead = rdv; if32.MemWrite = wrv;
         if32.a = 9'(addr);   if32.wd = wd[31:0]; if32.Funct3 = f3;
      end
      rdy = d64 ? if64.req_ready : if32.req_ready;
      if (v) begin
         n_chk++;
         if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready%0d: got %b, want 1", d64 ? 64 : 32, rdy);
         end
      end
      e.cyc = cyc + 2;
      @(posedge clk);
      if (v && rdy === 1'b1) begin
         model(d64, rdv, wrv, addr, wd, f3, flt, rd);
         e.rd  = lit ? lrd  : rd;
         e.flt = lit ? lflt : flt;
         if (d64) q64.push_back(e);
         else     q32.push_back(e);
      end
      #1;
      if32.req_valid = 1'b0;
      if64.req_valid = 1'b0;
   endtask

   task automatic ld(input bit d64, input int unsigned addr, input logic [2:0] f3,
                     input logic [63:0] exp_rd, input bit exp_flt);
      issue(d64, 1'b1, 1'b1, 1'b0, addr, 64'h0, f3, 1'b1, exp_rd, exp_flt);
   endtask

   task automatic st(input bit d64, input int unsigned addr, input logic [63:0] wd,
                     input logic [2:0] f3, input bit exp_flt);
      issue(d64, 1'b1, 1'b0, 1'b1, addr, wd, f3, 1'b1, 64'h0, exp_flt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q32.delete();
      q64.delete();
      foreach (m32[i]) m32[i] = 8'h00;
      foreach (m64[i]) m64[i] = 8'h00;
      @(negedge clk);
      n_chk++;
      if (if32.req_ready !== 1'b0 || if32.rsp_valid !== 1'b0 || if32.rd !== 32'h0 || if32.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset32: got ready=%b rsp_valid=%b rd=%h fault=%b, want all 0",
                  if32.req_ready, if32.rsp_valid, if32.rd, if32.fault);
      end
      n_chk++;
      if (if64.req_ready !== 1'b0 || if64.rsp_valid !== 1'b0 || if64.rd !== 64'h0 || if64.fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset64: got ready=%b rsp_valid=%b rd=%h fault=%b, want all 0",
                  if64.req_ready, if64.rsp_valid, if64.rd, if64.fault);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Count not-ready cycles after reset release; bounded so a stuck clear still ends
   task automatic wait_clear();
      int c32, c64;
      bit d32, dd64;
      c32 = 0; c64 = 0; d32 = 1'b0; dd64 = 1'b0;
      for (int i = 0; i < 300 && !(d32 && dd64); i++) begin
         @(negedge clk);
         if (!d32)  begin if (if32.req_ready === 1'b1) d32  = 1'b1; else c32++; end
         if (!dd64) begin if (if64.req_ready === 1'b1) dd64 = 1'b1; else c64++; end
      end
      n_chk++;
      if (!d32 || c32 != 128) begin
         n_fail++;
         $display("FAIL clear32: got %0d not-ready cycles (rose=%b), want 128", c32, d32);
      end
      n_chk++;
      if (!dd64 || c64 != 128) begin
         n_fail++;
         $display("FAIL clear64: got %0d not-ready cycles (rose=%b), want 128", c64, dd64);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      bit          d, v, rdv, wrv;
      int unsigned op, addr;
      logic [2:0]  f3;
      logic [63:0] wd;

      if32.req_valid = 1'b0; if32.MemRead = 1'b0; if32.MemWrite = 1'b0;
      if32.a = '0; if32.wd = '0; if32.Funct3 = '0;
      if64.req_valid = 1'b0; if64.MemRead = 1'b0; if64.MemWrite = 1'b0;
      if64.a = '0; if64.wd = '0; if64.Funct3 = '0;

      do_reset();
      wait_clear();

      // Fresh array reads zero
      ld(0, 'h10, 3'b010, 64'h0, 1'b0);

      // Store then back-to-back loads of various widths/extensions
      st(0, 'h20, 64'h80FF7F01, 3'b010, 1'b0);
      ld(0, 'h21, 3'b000, 64'h0000_0000_0000_007F, 1'b0);
      ld(0, 'h23, 3'b000, 64'h0000_0000_FFFF_FF80, 1'b0);
      ld(0, 'h23, 3'b100, 64'h0000_0000_0000_0080, 1'b0);
      ld(0, 'h22, 3'b101, 64'h0000_0000_0000_80FF, 1'b0);

      // Partial stores merge into the word
      st(0, 'h22, 64'h123456AA, 3'b000, 1'b0);
      ld(0, 'h20, 3'b010, 64'h0000_0000_80AA_7F01, 1'b0);
      st(0, 'h20, 64'h0000BEEF, 3'b001, 1'b0);
      ld(0, 'h20, 3'b010, 64'h0000_0000_80AA_BEEF, 1'b0);

      // Faults: misaligned load/store, no write, both-flags, 64-bit on 32
      ld(0, 'h21, 3'b001, 64'h0, 1'b1);
      st(0, 'h22, 64'hDEADBEEF, 3'b010, 1'b1);
      ld(0, 'h20, 3'b010, 64'h0000_0000_80AA_BEEF, 1'b0);
      issue(0, 1'b1, 1'b1, 1'b1, 'h20, 64'h11111111, 3'b010, 1'b1, 64'h0, 1'b1);
      ld(0, 'h20, 3'b011, 64'h0, 1'b1);
      issue(0, 1'b1, 1'b0, 1'b0, 'h20, 64'h0, 3'b010, 1'b1, 64'h0, 1'b1);
      issue(0, 1'b1, 1'b0, 1'b1, 'h20, 64'h0, 3'b100, 1'b1, 64'h0, 1'b1);

      // 64-bit instance
      st(1, 'h08, 64'hFEDCBA9876543210, 3'b011, 1'b0);
      ld(1, 'h0C, 3'b010, 64'hFFFF_FFFF_FEDC_BA98, 1'b0);
      ld(1, 'h0C, 3'b110, 64'h0000_0000_FEDC_BA98, 1'b0);
      ld(1, 'h08, 3'b011, 64'hFEDC_BA98_7654_3210, 1'b0);
      ld(1, 'h0C, 3'b011, 64'h0, 1'b1);

      // Randomized traffic on both instances, including idle cycles
      for (int k = 0; k < 600; k++) begin
         d    = 1'($urandom_range(0, 1));
         op   = $urandom_range(0, 19);
         f3   = 3'($urandom_range(0, 7));
         rdv  = (op < 9) || (op == 18);
         wrv  = (op >= 9 && op < 18) || (op == 18);
         addr = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 1);
         wd   = {$urandom(), $urandom()};
         v    = ($urandom_range(0, 9) != 0);
         issue(d, v, rdv, wrv, addr, wd, f3, 1'b0, 64'h0, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset with a load in flight drops its response
      st(0, 'h0C, 64'h12345678, 3'b010, 1'b0);
      issue(0, 1'b1, 1'b1, 1'b0, 'h0C, 64'h0, 3'b010, 1'b0, 64'h0, 1'b0);
      do_reset();
      repeat (50) @(posedge clk);
      #1;
      // Reset again mid-clear: the sweep restarts from word 0
      do_reset();
      wait_clear();
      ld(0, 'h0C, 3'b010, 64'h0, 1'b0);
      ld(1, 'h08, 3'b011, 64'h0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (q32.size() != 0 || q64.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending responses, want 0/0", q32.size(), q64.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_lsu_mem.md
# dm_lsu_mem

Parametrised, handshaked data memory for the RISC-V pipeline's MEM stage. It replaces the fixed 32-bit, combinational-decode data memory with a byte-lane RAM that has:
- synchronous one-cycle reads and a registered response;
- the full RV32/RV64 load/store width set, including unsigned loads;
- misalignment and illegal-access faults;
- a post-reset sequential clear of the whole array.

## Interface
Parameters:
- DM_ADDRESS, 9: byte-address width; capacity is 2^DM_ADDRESS bytes.
- DATA_W, 32: word width; legal values are 32 and 64. Derived: NB = DATA_W/8 lanes, LB = log2(NB), DEPTH = 2^(DM_ADDRESS-LB) words.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- MemRead  in  1  load request (from control unit).
- MemWrite  in  1  store request (from control unit).
- a  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data, right-aligned.
- Funct3  in  3  instruction bits 14:12.
- rsp_valid  out  1  one-cycle pulse: response for the request accepted in the previous cycle.
- rd  out  DATA_W  load data, already extended.
- fault  out  1  qualifies rsp_valid; set when the request was not performed.

## Operation
- States are CLEAR, IDLE and RUN.
  - Reset forces CLEAR with the clear counter at 0.
  - CLEAR: writes all-zero with all byte enables to word[counter], one word per cycle. After DEPTH cycles it moves to IDLE.
  - IDLE and RUN both accept requests. RUN means a response is due in the next cycle.
- req_ready = 1 in IDLE and RUN, 0 in CLEAR. No response backpressure, so one request per cycle is sustained.
- Access size comes from Funct3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Load extension:
  - Funct3[2] = 1 selects zero-extension (LBU, LHU, LWU).
  - Funct3[2] = 0 selects sign-extension.
- Lane selection:
  - lane = a[LB-1:0]; word index = a[DM_ADDRESS-1:LB].
  - Stores: wd is shifted left by 8*lane, and the byte enables form a contiguous mask of size bytes starting at lane.
- A request faults when any of the following holds. A faulting request performs no write and returns fault=1 and rd=0.
  - The address is misaligned: a mod size != 0.
  - The access is 64-bit or LWU while DATA_W=32.
  - Funct3 is 111.
  - Funct3 is 1xx on a store.
  - MemRead and MemWrite are both 1.
  - MemRead and MemWrite are both 0.
- Stores return rsp_valid with fault=0 and rd=0.
- Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1 or later. The array is written at edge N and read at edge N+1, so no forwarding is required.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rd=0, fault=0, state=CLEAR, counter=0.
- Reset asserted at any point, including mid-CLEAR or with a request in flight:
  - the in-flight response is dropped;
  - CLEAR restarts from word 0.
- Request accepted at edge N:
  - the array read/write happens at edge N;
  - rsp_valid, rd and fault are registered and valid after edge N+1;
  - load latency is 1 cycle after acceptance.
- rsp_valid lasts exactly one cycle per accepted request. Back-to-back requests produce back-to-back responses.
- req_ready first rises DEPTH cycles after reset deassertion (128 for the defaults).
- Inputs are ignored when req_valid=0 or req_ready=0.

## Structure
- Package dm_lsu_pkg holds:
  - the Funct3 size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the unsigned flag bit index;
  - the state enum (CLEAR, IDLE, RUN);
  - a function returning the byte-enable mask for (size, lane, NB).
- Sub-module dm_bram: DEPTH x DATA_W array with a per-byte write enable and a synchronous read port. One port with write priority; read data on a write cycle is don't-care.
- The top level holds the FSM, clear counter, decode/fault logic, store shifter, and the registered load aligner/extender. The aligner uses lane and size values registered from the request cycle.

## Test plan
- Reset, then release: req_ready is 0 for exactly 128 cycles, then 1. LW at 0x10 returns rd=0x00000000 with fault=0 one cycle after acceptance.
- SW 0x80FF7F01 at 0x20, then LB 0x21, LB 0x23, LBU 0x23 and LHU 0x22 back-to-back:
  - LB 0x21 → 0x0000007F;
  - LB 0x23 → 0xFFFFFF80;
  - LBU 0x23 → 0x00000080;
  - LHU 0x22 → 0x000080FF;
  - all on consecutive cycles, with the first load response arriving the cycle after the store response.
- SB wd=0x123456AA at 0x22, then LW 0x20 → 0x80AA7F01. SH 0xBEEF at 0x20, then LW 0x20 → 0x80AABEEF.
- Fault cases:
  - LH at 0x21 → fault=1, rd=0;
  - SW 0xDEADBEEF at 0x22 → fault=1;
  - a following LW 0x20 is unchanged (0x80AABEEF);
  - MemRead=MemWrite=1 → fault=1;
  - LD on DATA_W=32 → fault=1.
- Reset asserted at clear cycle 50 after a store made word 3 nonzero: after release, req_ready stays 0 for 128 full cycles. LW 0x0C then returns 0.
- DATA_W=64, DM_ADDRESS=10: SD 0xFEDCBA9876543210 at 0x08, then:
  - LW 0x0C → 0xFFFFFFFFFEDCBA98;
  - LWU 0x0C → 0x00000000FEDCBA98;
  - LD 0x08 returns the stored value;
  - LD 0x0C → fault.
